prbs16_checker: RTL and testbench
=================================

// Module: prbs16_checker
// PURPOSE
//   Receive-side checker for the 16-bit Fibonacci PRBS stream produced by the on-chip
//   noise generator (taps 16,14,13,11: x^16+x^14+x^13+x^11+1; serial bit = stage 16).
//   Self-synchronises to an incoming bit stream sampled on a strobe, declares lock,
//   then counts bit errors against a free-running local reference and drops lock on burst errors.
// PARAMETERS
//   SYNC_RUN     32   consecutive correct predictions in VERIFY required to enter LOCKED
//   LOSS_WIN     64   LOCKED observation window length, in valid bits
//   LOSS_THRESH  8    errors within one window that force return to HUNT (1..LOSS_WIN)
//   ERR_W        16   width of err_count (saturating)
//   BITS_W       24   width of bit_count (saturating)
// PORTS
//   clk          in   1       system clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   bit_valid    in   1       sample strobe; bit_in consumed on rising clk edge when high
//   bit_in       in   1       received PRBS bit
//   clear        in   1       synchronous clear of err_count and bit_count (state untouched)
//   locked       out  1       high while FSM is in LOCKED
//   err_pulse    out  1       one-cycle pulse: mismatch detected on a LOCKED valid bit
//   sync_lost    out  1       one-cycle pulse: LOCKED -> HUNT transition
//   err_count    out  ERR_W   errors counted while LOCKED, saturates at all-ones
//   bit_count    out  BITS_W  valid bits checked while LOCKED, saturates at all-ones
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=HUNT, shift reg=0, fill/run/window counters=0,
//     all outputs 0. Release takes effect on next clk edge.
//   - All outputs registered; nothing changes on cycles with bit_valid=0 except clear.
//   - exp = sr[15]^sr[13]^sr[12]^sr[10] (sr[15]=stage 16); decision visible 1 cycle after strobe edge.
//   - HUNT: shift bit_in into sr; fill++ (saturate at 16). When fill==16 and sr!=0 after the
//     shift -> VERIFY, run=0. All-zero sr never leaves HUNT (lock-up pattern rejected).
//   - VERIFY: compare bit_in vs exp, shift bit_in into sr. Match: run++; run reaching SYNC_RUN
//     -> LOCKED, window counters=0. Mismatch: run=0, stay VERIFY. No errors counted.
//   - LOCKED: shift exp (not bit_in) into sr -- local reference free-runs, no error
//     multiplication. bit_count++; on mismatch err_pulse=1, err_count++, win_err++.
//     win_bits++; when win_bits reaches LOSS_WIN both window counters reset to 0.
//     win_err reaching LOSS_THRESH -> HUNT, fill=0, sync_lost=1 for one cycle, locked=0.
//   - Simultaneous: error on the bit that completes a window counts in that window, then
//     window resets. clear with an error on same edge: counters forced to 0, err_pulse
//     still asserts. clear never affects state, sr, or window counters.
//   - Saturating counters hold all-ones; never wrap. Counters retained across lock loss.
//   - Reset mid-operation: immediate return to reset values regardless of state.
// TESTING
//   1 Generator seeded 16'hACE1, continuous strobe -> locked rises after 16+32 valid bits,
//     err_count=0 after 1000 further bits, bit_count=1000.
//   2 Locked, flip one bit_in every 20 bits for 200 bits -> 10 err_pulse, err_count=10,
//     locked stays 1 (max 4 errors per 64-bit window).
//   3 Locked, invert 8 consecutive bits -> sync_lost pulse on 8th, locked=0, relock after 48 bits.
//   4 All-zero input for 500 bits -> never leaves HUNT, locked=0, err_count=0.
//   5 ERR_W=4, persistent errors below threshold -> err_count sticks at 4'hF; clear -> 0.
//   6 rst_n pulsed low mid-LOCKED (async, between edges) -> all outputs 0 immediately.

Source files
------------

// File: rtl/prbs16_checker_if.sv
// prbs16_checker_if
//   Bit-stream and status bundle for prbs16_checker.
//   master : drives bit_valid, bit_in, clear; observes the status outputs
//   slave  : the checker itself
//   bit_valid  sample strobe
//   bit_in     received PRBS bit
//   clear      synchronous clear of err_count / bit_count
//   locked     checker is tracking the stream
//   err_pulse  one-cycle pulse per mismatch seen while locked
//   sync_lost  one-cycle pulse on loss of lock
//   err_count  saturating error count (ERR_W bits)
//   bit_count  saturating checked-bit count (BITS_W bits)
interface prbs16_checker_if #(
  parameter int unsigned ERR_W  = 16,
  parameter int unsigned BITS_W = 24
);
  logic              bit_valid;
  logic              bit_in;
  logic              clear;
  logic              locked;
  logic              err_pulse;
  logic              sync_lost;
  logic [ERR_W-1:0]  err_count;
  logic [BITS_W-1:0] bit_count;

  modport master (
    output bit_valid, bit_in, clear,
    input  locked, err_pulse, sync_lost, err_count, bit_count
  );

  modport slave (
    input  bit_valid, bit_in, clear,
    output locked, err_pulse, sync_lost, err_count, bit_count
  );
endinterface

// File: rtl/prbs16_checker.sv
// prbs16_checker
//   Receive-side checker for the x^16+x^14+x^13+x^11+1 Fibonacci PRBS
//   (serial bit = stage 16). Hunts for 16 non-zero bits, verifies SYNC_RUN
//   consecutive predictions, then free-runs a local reference and counts
//   errors. LOSS_THRESH errors inside one LOSS_WIN-bit window drop lock.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : prbs16_checker_if.slave (strobe/bit/clear in, status out)
module prbs16_checker #(
  parameter int unsigned SYNC_RUN    = 32,
  parameter int unsigned LOSS_WIN    = 64,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned BITS_W      = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  prbs16_checker_if.slave bus
);
  localparam int unsigned RUN_W = $clog2(SYNC_RUN + 1);
  localparam int unsigned WIN_W = $clog2(LOSS_WIN + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state;
  logic [15:0]       sr;
  logic [4:0]        fill;
  logic [RUN_W-1:0]  run;
  logic [WIN_W-1:0]  win_bits;
  logic [WIN_W-1:0]  win_err;
  logic              locked_q;
  logic              err_pulse_q;
  logic              sync_lost_q;
  logic [ERR_W-1:0]  err_q;
  logic [BITS_W-1:0] bits_q;

  logic              exp_bit;
  logic              mismatch;
  logic [15:0]       sr_rx;
  logic [15:0]       sr_ref;

  always_comb begin
    exp_bit  = sr[15] ^ sr[13] ^ sr[12] ^ sr[10];
    mismatch = bus.bit_in ^ exp_bit;
    sr_rx    = {sr[14:0], bus.bit_in};
    sr_ref   = {sr[14:0], exp_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      sr          <= '0;
      fill        <= '0;
      run         <= '0;
      win_bits    <= '0;
      win_err     <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      sync_lost_q <= 1'b0;
      err_q       <= '0;
      bits_q      <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      sync_lost_q <= 1'b0;
      if (bus.bit_valid) begin
        case (state)
          HUNT: begin
            sr <= sr_rx;
            if (fill != 5'd16) fill <= fill + 5'd1;
            // fill >= 15 here means the register is full once this bit lands
            if (fill >= 5'd15 && sr_rx != '0) begin
              state <= VERIFY;
              run   <= '0;
            end
          end
          VERIFY: begin
            sr <= sr_rx;
            if (mismatch) begin
              run <= '0;
            end else if (run == RUN_W'(SYNC_RUN - 1)) begin
              state    <= LOCKED;
              locked_q <= 1'b1;
              win_bits <= '0;
              win_err  <= '0;
            end else begin
              run <= run + RUN_W'(1);
            end
          end
          LOCKED: begin
            // reference free-runs on its own prediction, so a bad bit is
            // counted once instead of being fed back into later predictions
            sr <= sr_ref;
            if (bits_q != '1) bits_q <= bits_q + BITS_W'(1);
            if (mismatch) begin
              err_pulse_q <= 1'b1;
              if (err_q != '1) err_q <= err_q + ERR_W'(1);
            end
            // threshold is tested on the pre-increment count so an error on
            // the window-closing bit still belongs to that window
            if (mismatch && win_err == WIN_W'(LOSS_THRESH - 1)) begin
              state       <= HUNT;
              fill        <= '0;
              locked_q    <= 1'b0;
              sync_lost_q <= 1'b1;
              win_bits    <= '0;
              win_err     <= '0;
            end else if (win_bits == WIN_W'(LOSS_WIN - 1)) begin
              win_bits <= '0;
              win_err  <= '0;
            end else begin
              win_bits <= win_bits + WIN_W'(1);
              win_err  <= win_err + WIN_W'(mismatch);
            end
          end
          default: state <= HUNT;
        endcase
      end
      if (bus.clear) begin
        err_q  <= '0;
        bits_q <= '0;
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.sync_lost = sync_lost_q;
  assign bus.err_count = err_q;
  assign bus.bit_count = bits_q;
endmodule

// File: tb/tb_prbs16_checker.sv
// tb_prbs16_checker
//   Directed sequence with random strobe gaps driving two checkers (wide and
//   narrow counters) from one PRBS source; every cycle is compared against a
//   bit-history reference model.
module tb_prbs16_checker;
  localparam int unsigned SYNC_RUN    = 32;
  localparam int unsigned LOSS_WIN    = 64;
  localparam int unsigned LOSS_THRESH = 8;
  localparam longint MAX_ERR16  = 65535;
  localparam longint MAX_BITS16 = 16777215;
  localparam longint MAX_ERR4   = 15;
  localparam longint MAX_BITS4  = 63;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_in = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  prbs16_checker_if bus16 ();
  prbs16_checker_if #(.ERR_W(4), .BITS_W(6)) bus4 ();

  assign bus16.bit_valid = bit_valid;
  assign bus16.bit_in    = bit_in;
  assign bus16.clear     = clear;
  assign bus4.bit_valid  = bit_valid;
  assign bus4.bit_in     = bit_in;
  assign bus4.clear      = clear;

  prbs16_checker #(.SYNC_RUN(SYNC_RUN), .LOSS_WIN(LOSS_WIN), .LOSS_THRESH(LOSS_THRESH),
                   .ERR_W(16), .BITS_W(24))
    dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  prbs16_checker #(.SYNC_RUN(SYNC_RUN), .LOSS_WIN(LOSS_WIN), .LOSS_THRESH(LOSS_THRESH),
                   .ERR_W(4), .BITS_W(6))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: last 16 reference bits, oldest first
  bit     hist[$];
  int     m_mode;   // 0 searching, 1 confirming, 2 tracking
  int     m_fill, m_run, m_wbits, m_werr;
  longint m_err16, m_bits16, m_err4, m_bits4;
  bit     m_locked, m_pulse, m_lost;

  logic [15:0] g;
  int pulses;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 16; i++) hist.push_back(1'b0);
    m_mode = 0; m_fill = 0; m_run = 0; m_wbits = 0; m_werr = 0;
    m_err16 = 0; m_bits16 = 0; m_err4 = 0; m_bits4 = 0;
    m_locked = 0; m_pulse = 0; m_lost = 0;
  endtask

  task automatic push(input bit b);
    hist.push_back(b);
    void'(hist.pop_front());
  endtask

  task automatic model_step(input logic v, input logic b, input logic clr);
    bit pred;
    bit any1;
    m_pulse = 0;
    m_lost  = 0;
    if (v) begin
      // s[n] = s[n-16] ^ s[n-14] ^ s[n-13] ^ s[n-11]
      pred = hist[0] ^ hist[2] ^ hist[3] ^ hist[5];
      if (m_mode == 0) begin
        push(b);
        if (m_fill < 16) m_fill++;
        any1 = 0;
        foreach (hist[i]) any1 |= hist[i];
        if (m_fill == 16 && any1) begin m_mode = 1; m_run = 0; end
      end else if (m_mode == 1) begin
        push(b);
        if (b == pred) begin
          m_run++;
          if (m_run == SYNC_RUN) begin
            m_mode = 2; m_locked = 1; m_wbits = 0; m_werr = 0;
          end
        end else begin
          m_run = 0;
        end
      end else begin
        push(pred);
        if (m_bits16 < MAX_BITS16) m_bits16++;
        if (m_bits4 < MAX_BITS4) m_bits4++;
        m_wbits++;
        if (b != pred) begin
          m_pulse = 1;
          if (m_err16 < MAX_ERR16) m_err16++;
          if (m_err4 < MAX_ERR4) m_err4++;
          m_werr++;
        end
        if (m_werr == LOSS_THRESH) begin
          m_mode = 0; m_fill = 0; m_locked = 0; m_lost = 1; m_wbits = 0; m_werr = 0;
        end else if (m_wbits == LOSS_WIN) begin
          m_wbits = 0; m_werr = 0;
        end
      end
    end
    if (clr) begin
      m_err16 = 0; m_bits16 = 0; m_err4 = 0; m_bits4 = 0;
    end
  endtask

  task automatic check_all();
    chk("locked",     64'(bus16.locked),    64'(m_locked));
    chk("err_pulse",  64'(bus16.err_pulse), 64'(m_pulse));
    chk("sync_lost",  64'(bus16.sync_lost), 64'(m_lost));
    chk("err_count",  64'(bus16.err_count), 64'(m_err16));
    chk("bit_count",  64'(bus16.bit_count), 64'(m_bits16));
    chk("locked_n",   64'(bus4.locked),     64'(m_locked));
    chk("err_count_n", 64'(bus4.err_count), 64'(m_err4));
    chk("bit_count_n", 64'(bus4.bit_count), 64'(m_bits4));
  endtask

  task automatic step(input logic v, input logic b, input logic clr);
    bit_valid = v;
    bit_in    = b;
    clear     = clr;
    @(posedge clk);
    model_step(v, b, clr);
    #1;
    check_all();
    if (bus16.err_pulse === 1'b1) pulses++;
  endtask

  task automatic next_gen(output logic b);
    b = g[15];
    g = {g[14:0], g[15] ^ g[13] ^ g[12] ^ g[10]};
  endtask

  // optional random idle cycle, then one valid bit (optionally inverted)
  task automatic send(input bit gaps, input bit flip, input logic clr);
    logic b;
    if (gaps && $urandom_range(0, 3) == 0) step(1'b0, 1'($urandom), 1'b0);
    next_gen(b);
    step(1'b1, b ^ flip, clr);
  endtask

  initial begin
    model_reset();
    g = 16'hACE1;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // acquisition: 16 fill + 32 verify bits, continuous strobe
    for (int i = 1; i <= 48; i++) begin
      send(1'b0, 1'b0, 1'b0);
      if (i == 47) chk("t1_not_locked_47", 64'(bus16.locked), 64'd0);
    end
    chk("t1_locked_48", 64'(bus16.locked), 64'd1);
    for (int i = 0; i < 1000; i++) send(1'b0, 1'b0, 1'b0);
    chk("t1_err0", 64'(bus16.err_count), 64'd0);
    chk("t1_bits1000", 64'(bus16.bit_count), 64'd1000);

    // sparse errors: 10 over 200 bits, never more than 4 per window
    pulses = 0;
    for (int i = 0; i < 200; i++) send(1'b1, (i % 20) == 19, 1'b0);
    chk("t2_pulses", 64'(pulses), 64'd10);
    chk("t2_err10", 64'(bus16.err_count), 64'd10);
    chk("t2_locked", 64'(bus16.locked), 64'd1);

    // clean gap so the current window holds no earlier errors
    for (int i = 0; i < 130; i++) send(1'b1, 1'b0, 1'b0);

    // burst of 8 inverted bits drops lock on the 8th
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 1'b1, 1'b0);
      chk("t3_sync_lost", 64'(bus16.sync_lost), 64'(i == 7));
    end
    chk("t3_unlocked", 64'(bus16.locked), 64'd0);
    for (int i = 1; i <= 48; i++) begin
      send(1'b0, 1'b0, 1'b0);
      if (i == 47) chk("t3_relock_47", 64'(bus16.locked), 64'd0);
    end
    chk("t3_relock_48", 64'(bus16.locked), 64'd1);

    // saturation of the narrow counters, clear colliding with an error
    step(1'b0, 1'b0, 1'b1);
    chk("t5_clear0", 64'(bus4.err_count), 64'd0);
    for (int i = 0; i < 600; i++) begin
      send(1'b1, (i % 20) == 19, i == 99);
      if (i == 99) begin
        chk("t5_clr_pulse", 64'(bus16.err_pulse), 64'd1);
        chk("t5_clr_err", 64'(bus16.err_count), 64'd0);
      end
    end
    chk("t5_err4_sat", 64'(bus4.err_count), 64'd15);
    chk("t5_bits4_sat", 64'(bus4.bit_count), 64'd63);
    chk("t5_err16", 64'(bus16.err_count), 64'd25);
    chk("t5_locked", 64'(bus16.locked), 64'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("t5_clear_err4", 64'(bus4.err_count), 64'd0);
    chk("t5_clear_bits16", 64'(bus16.bit_count), 64'd0);

    // async reset between edges while locked
    send(1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_locked", 64'(bus16.locked), 64'd0);
    chk("t6_err_pulse", 64'(bus16.err_pulse), 64'd0);
    chk("t6_err", 64'(bus16.err_count), 64'd0);
    chk("t6_bits", 64'(bus4.bit_count), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // all-zero input never leaves the search phase
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom), 1'b0);
      step(1'b1, 1'b0, 1'b0);
    end
    chk("t4_locked", 64'(bus16.locked), 64'd0);
    chk("t4_err", 64'(bus16.err_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
